// File: rtl/collision_scanner.sv
//------------------------------------------------------------------------------
// Module      : collision_scanner
// Description : Sequential box-overlap engine. One probe rectangle is tested
//               against NUM_TGT target rectangles, one slot per clock, through
//               a single shared comparator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module collision_scanner #(
    parameter int COORD_W = 10,
    parameter int NUM_TGT = 8,
    localparam int IDX_W  = $clog2(NUM_TGT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       strict,
    input  logic [COORD_W-1:0]         p_x1,
    input  logic [COORD_W-1:0]         p_x2,
    input  logic [COORD_W-1:0]         p_y1,
    input  logic [COORD_W-1:0]         p_y2,
    input  logic [NUM_TGT*COORD_W-1:0] t_x1,
    input  logic [NUM_TGT*COORD_W-1:0] t_x2,
    input  logic [NUM_TGT*COORD_W-1:0] t_y1,
    input  logic [NUM_TGT*COORD_W-1:0] t_y2,
    input  logic [NUM_TGT-1:0]         t_en,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_TGT-1:0]         hit_mask,
    output logic                       hit_any,
    output logic [IDX_W-1:0]           first_hit,
    output logic                       bad_box
);

    localparam logic [0:0]       c_st_idle  = 1'b0;
    localparam logic [0:0]       c_st_scan  = 1'b1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_TGT - 1);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic [NUM_TGT-1:0] r_hit_mask;
    logic               r_hit_any;
    logic [IDX_W-1:0]   r_first_hit;
    logic               r_bad_box;

    logic               r_strict;
    logic [NUM_TGT-1:0] r_en;
    logic [COORD_W-1:0] r_px1, r_px2, r_py1, r_py2;
    logic [COORD_W-1:0] r_tx1 [NUM_TGT];
    logic [COORD_W-1:0] r_tx2 [NUM_TGT];
    logic [COORD_W-1:0] r_ty1 [NUM_TGT];
    logic [COORD_W-1:0] r_ty2 [NUM_TGT];

    logic               w_accept;
    logic [COORD_W-1:0] w_tx1, w_tx2, w_ty1, w_ty2;
    logic               w_en;
    logic               w_probe_bad;
    logic               w_tgt_bad;
    logic               w_overlap;
    logic               w_hit;
    logic               w_flag_bad;

    assign w_accept = start & ~rst & (r_state == c_st_idle);

    // Whole request is snapshotted so upstream may change the bus during a scan.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_strict <= strict;
            r_en     <= t_en;
            r_px1    <= p_x1;
            r_px2    <= p_x2;
            r_py1    <= p_y1;
            r_py2    <= p_y2;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_tx1[gi] <= t_x1[gi*COORD_W +: COORD_W];
                    r_tx2[gi] <= t_x2[gi*COORD_W +: COORD_W];
                    r_ty1[gi] <= t_y1[gi*COORD_W +: COORD_W];
                    r_ty2[gi] <= t_y2[gi*COORD_W +: COORD_W];
                end
            end
        end
    endgenerate

    always_comb begin
        w_tx1       = r_tx1[r_idx];
        w_tx2       = r_tx2[r_idx];
        w_ty1       = r_ty1[r_idx];
        w_ty2       = r_ty2[r_idx];
        w_en        = r_en[r_idx];
        w_probe_bad = (r_px1 > r_px2) | (r_py1 > r_py2);
        w_tgt_bad   = (w_tx1 > w_tx2) | (w_ty1 > w_ty2);
        if (r_strict) begin
            w_overlap = (r_px2 > w_tx1) & (r_px1 < w_tx2) &
                        (r_py1 < w_ty2) & (r_py2 > w_ty1);
        end else begin
            w_overlap = (r_px2 >= w_tx1) & (r_px1 <= w_tx2) &
                        (r_py1 <= w_ty2) & (r_py2 >= w_ty1);
        end
        // Malformed boxes never hit, whatever the raw comparisons say.
        w_hit      = w_en & ~w_probe_bad & ~w_tgt_bad & w_overlap;
        w_flag_bad = w_probe_bad | (w_en & w_tgt_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_hit_mask  <= '0;
            r_hit_any   <= 1'b0;
            r_first_hit <= '0;
            r_bad_box   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_scan;
                        r_idx       <= '0;
                        r_hit_mask  <= '0;
                        r_hit_any   <= 1'b0;
                        r_first_hit <= '0;
                        r_bad_box   <= 1'b0;
                    end
                end
                c_st_scan: begin
                    r_hit_mask[r_idx] <= w_hit;
                    r_hit_any         <= r_hit_any | w_hit;
                    r_bad_box         <= r_bad_box | w_flag_bad;
                    if (w_hit && !r_hit_any) begin
                        r_first_hit <= r_idx;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy      = (r_state == c_st_scan);
    assign done      = r_done;
    assign hit_mask  = r_hit_mask;
    assign hit_any   = r_hit_any;
    assign first_hit = r_first_hit;
    assign bad_box   = r_bad_box;

endmodule

`default_nettype wire

// File: tb/tb_collision_scanner.sv
//------------------------------------------------------------------------------
// Module      : tb_collision_scanner
// Description : Self-checking bench for collision_scanner: directed cases plus
//               randomized scans against a box-overlap reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_collision_scanner;

    localparam int CW = 10;
    localparam int NT = 8;
    localparam int IW = $clog2(NT);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             strict;
    logic [CW-1:0]    p_x1, p_x2, p_y1, p_y2;
    logic [NT*CW-1:0] t_x1, t_x2, t_y1, t_y2;
    logic [NT-1:0]    t_en;
    logic             busy, done, hit_any, bad_box;
    logic [NT-1:0]    hit_mask;
    logic [IW-1:0]    first_hit;

    int checks = 0;
    int errors = 0;

    // Stimulus description as plain integers; the model works from these.
    int unsigned px1, px2, py1, py2;
    int unsigned tx1 [NT];
    int unsigned tx2 [NT];
    int unsigned ty1 [NT];
    int unsigned ty2 [NT];
    logic [NT-1:0] ten;
    bit            st;

    logic [NT-1:0] exp_mask;
    int            exp_first;
    bit            exp_bad;

    collision_scanner #(.COORD_W(CW), .NUM_TGT(NT)) dut (
        .clk(clk), .rst(rst), .start(start), .strict(strict),
        .p_x1(p_x1), .p_x2(p_x2), .p_y1(p_y1), .p_y2(p_y2),
        .t_x1(t_x1), .t_x2(t_x2), .t_y1(t_y1), .t_y2(t_y2), .t_en(t_en),
        .busy(busy), .done(done), .hit_mask(hit_mask), .hit_any(hit_any),
        .first_hit(first_hit), .bad_box(bad_box)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input int unsigned a1, input int unsigned a2,
                                    input int unsigned b1, input int unsigned b2, input bit s);
        return s ? (a2 > b1 && a1 < b2) : (a2 >= b1 && a1 <= b2);
    endfunction

    task automatic model();
        bit pbad;
        pbad      = (px1 > px2) || (py1 > py2);
        exp_mask  = '0;
        exp_bad   = pbad;
        exp_first = 0;
        for (int i = 0; i < NT; i++) begin
            if (ten[i]) begin
                if (tx1[i] > tx2[i] || ty1[i] > ty2[i]) exp_bad = 1'b1;
                else if (!pbad && overlaps(px1, px2, tx1[i], tx2[i], st)
                               && overlaps(py1, py2, ty1[i], ty2[i], st))
                    exp_mask[i] = 1'b1;
            end
        end
        for (int i = NT - 1; i >= 0; i--) if (exp_mask[i]) exp_first = i;
    endtask

    task automatic apply_bus();
        strict = st;
        t_en   = ten;
        p_x1 = CW'(px1); p_x2 = CW'(px2); p_y1 = CW'(py1); p_y2 = CW'(py2);
        for (int i = 0; i < NT; i++) begin
            t_x1[i*CW +: CW] = CW'(tx1[i]);
            t_x2[i*CW +: CW] = CW'(tx2[i]);
            t_y1[i*CW +: CW] = CW'(ty1[i]);
            t_y2[i*CW +: CW] = CW'(ty2[i]);
        end
    endtask

    task automatic scramble_bus();
        strict = 1'($urandom);
        t_en   = NT'($urandom);
        p_x1 = CW'($urandom); p_x2 = CW'($urandom);
        p_y1 = CW'($urandom); p_y2 = CW'($urandom);
        t_x1 = {NT{CW'($urandom)}}; t_x2 = {NT{CW'($urandom)}};
        t_y1 = {NT{CW'($urandom)}}; t_y2 = {NT{CW'($urandom)}};
    endtask

    task automatic setup_far(input int unsigned a1, input int unsigned a2,
                             input int unsigned b1, input int unsigned b2);
        px1 = a1; px2 = a2; py1 = b1; py2 = b2;
        for (int i = 0; i < NT; i++) begin
            tx1[i] = 900; tx2[i] = 950; ty1[i] = 900; ty2[i] = 950;
        end
        ten = '1;
        st  = 1'b0;
    endtask

    task automatic set_slot(input int i, input int unsigned a1, input int unsigned a2,
                            input int unsigned b1, input int unsigned b2);
        tx1[i] = a1; tx2[i] = a2; ty1[i] = b1; ty2[i] = b2;
    endtask

    // Called 1ns after a rising edge. Returns 1ns after the done edge, so an
    // immediate follow-up call exercises a start in the done cycle.
    task automatic scan_and_check(input string tag, input bit hold_check);
        int n;
        model();
        apply_bus();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_busy"}, busy, 1);
        check_val({tag, "_clr"}, {done, hit_any, bad_box, hit_mask}, 0);
        n = 0;
        while (done !== 1'b1 && n < NT + 4) begin
            start = (n == 2);
            scramble_bus();
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check_val({tag, "_lat"}, n, NT);
        check_val({tag, "_idle"}, busy, 0);
        check_val({tag, "_mask"}, hit_mask, exp_mask);
        check_val({tag, "_any"}, hit_any, |exp_mask);
        check_val({tag, "_first"}, first_hit, exp_first);
        check_val({tag, "_bad"}, bad_box, exp_bad);
        if (hold_check) begin
            @(posedge clk); #1;
            check_val({tag, "_dfall"}, {busy, done}, 0);
            check_val({tag, "_hold"}, {hit_any, bad_box, first_hit, hit_mask},
                      {|exp_mask, exp_bad, IW'(exp_first), exp_mask});
        end
    endtask

    task automatic rand_box(output int unsigned a1, output int unsigned a2,
                            output int unsigned b1, output int unsigned b2);
        int unsigned tmp;
        a1 = $urandom_range(0, 80); a2 = a1 + $urandom_range(0, 30);
        b1 = $urandom_range(0, 80); b2 = b1 + $urandom_range(0, 30);
        if ($urandom_range(0, 15) == 0) a2 = 1023;
        if ($urandom_range(0, 11) == 0) begin tmp = a1; a1 = a2 + 1; a2 = tmp; end
        if ($urandom_range(0, 11) == 0) begin tmp = b1; b1 = b2 + 1; b2 = tmp; end
    endtask

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0;
        setup_far(0, 0, 0, 0);
        apply_bus();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_state", {busy, done, hit_any, bad_box, first_hit, hit_mask}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        setup_far(100, 150, 100, 150);
        set_slot(3, 140, 200, 140, 200);
        scan_and_check("single", 1'b1);
        check_val("single_lit", {first_hit, hit_mask}, {3'd3, 8'h08});

        setup_far(100, 150, 100, 150);
        set_slot(0, 150, 200, 120, 130);
        scan_and_check("touch_ns", 1'b0);
        check_val("touch_ns_b0", hit_mask[0], 1);
        st = 1'b1;
        scan_and_check("touch_st", 1'b1);
        check_val("touch_st_b0", hit_mask[0], 0);

        setup_far(100, 150, 100, 150);
        set_slot(2, 90, 110, 90, 110);
        set_slot(5, 120, 130, 120, 130);
        set_slot(6, 150, 160, 150, 160);
        ten = 8'hDF;
        scan_and_check("multi", 1'b1);
        check_val("multi_lit", {first_hit, hit_mask}, {3'd2, 8'h44});

        setup_far(100, 150, 100, 150);
        set_slot(1, 200, 100, 100, 150);
        scan_and_check("badtgt", 1'b1);
        check_val("badtgt_lit", {bad_box, hit_mask[1]}, 2'b10);

        setup_far(100, 150, 150, 100);
        set_slot(3, 140, 200, 140, 200);
        scan_and_check("badprobe", 1'b1);
        check_val("badprobe_lit", {bad_box, hit_mask}, {1'b1, 8'h00});

        // Reset in the middle of a scan that would otherwise hit.
        setup_far(100, 150, 100, 150);
        set_slot(4, 140, 200, 140, 200);
        apply_bus();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mid", {busy, done, hit_any, bad_box, first_hit, hit_mask}, 0);
        rst = 1'b0; start = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < NT + 2; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check_val("rst_quiet", seen_done, 0);

        for (int r = 0; r < 40; r++) begin
            rand_box(px1, px2, py1, py2);
            for (int i = 0; i < NT; i++) rand_box(tx1[i], tx2[i], ty1[i], ty2[i]);
            ten = NT'($urandom);
            st  = 1'($urandom);
            scan_and_check($sformatf("rnd%0d", r), r[1:0] == 2'b11);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule

`default_nettype wire
